// File: rtl/gb80_alu_pkg.sv
// Shared definitions for the 16-bit add sequencer: op codes, flag bit positions, FSM states.
// Latency: none (declarations only).
// Backpressure: none.
package gb80_alu_pkg;

  // Operation select carried on i_op
  typedef enum logic [1:0] {
    OP_ADD16     = 2'b00,
    OP_ADD_SP_E8 = 2'b01,
    OP_INC16     = 2'b10,
    OP_DEC16     = 2'b11
  } op_e;

  // Bit positions inside the {Z,N,H,C} flag nibble
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  // Sequencer states: one byte-wide adder pass per LO/HI state
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10
  } state_e;

endpackage

// File: rtl/bit_adder.sv
// Byte-wide adder with carry-in, carry-out and nibble (half) carry.
// Latency: combinational.
// Backpressure: none.
module bit_adder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_cin,
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_cout,
  output logic                  o_hcarry
);

  // Full add; nibble carry recovered from the sum bit just above the low nibble
  always_comb begin
    {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DATA_WIDTH{1'b0}}, i_cin};
    o_hcarry        = i_a[4] ^ i_b[4] ^ o_sum[4];
  end

endmodule

// File: rtl/add16_sequencer.sv
// 16-bit add/inc/dec computed as two byte passes through one shared 8-bit adder.
// Latency: o_done/o_result/o_flags three cycles after i_start is sampled in IDLE.
// Backpressure: i_start ignored while busy; a new start is accepted in the o_done cycle.
// Build option: define ADD16_SP_OFFSET_EN to enable ADD_SP_E8; otherwise op 01 returns A and flags unchanged.
module add16_sequencer
  import gb80_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [15:0] i_op_a,
  input  logic [15:0] i_op_b,
  input  logic [3:0]  i_flags_in,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_result,
  output logic [3:0]  o_flags
);

  state_e           r_state;
  op_e              r_op;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [3:0]       r_flags_lat;
  logic [WIDTH-1:0] r_lo_sum;
  logic             r_c7;
  logic             r_c3;

  logic [15:0]      w_eff_b;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_hc;
  logic [15:0]      w_res;
  logic [3:0]       w_flg;

  // Effective B operand chosen from the requested operation
  always_comb begin
    w_eff_b = i_op_b;
    case (op_e'(i_op))
      OP_ADD16:     w_eff_b = i_op_b;
`ifdef ADD16_SP_OFFSET_EN
      OP_ADD_SP_E8: w_eff_b = {{8{i_op_b[7]}}, i_op_b[7:0]};
`else
      OP_ADD_SP_E8: w_eff_b = 16'h0000;
`endif
      OP_INC16:     w_eff_b = 16'h0001;
      OP_DEC16:     w_eff_b = 16'hFFFF;
      default:      w_eff_b = i_op_b;
    endcase
  end

  // Steer the shared adder: low bytes in LO, high bytes plus LO carry otherwise
  always_comb begin
    if (r_state == ST_LO) begin
      w_add_a   = r_a[WIDTH-1:0];
      w_add_b   = r_b[WIDTH-1:0];
      w_add_cin = 1'b0;
    end else begin
      w_add_a   = r_a[2*WIDTH-1:WIDTH];
      w_add_b   = r_b[2*WIDTH-1:WIDTH];
      w_add_cin = r_c7;
    end
  end

  bit_adder #(
    .DATA_WIDTH(WIDTH)
  ) u_bit_adder (
    .i_a      (w_add_a),
    .i_b      (w_add_b),
    .i_cin    (w_add_cin),
    .o_sum    (w_sum),
    .o_cout   (w_cout),
    .o_hcarry (w_hc)
  );

  // Final result and flags, valid while the HI pass is on the adder
  always_comb begin
    w_res = {w_sum, r_lo_sum};
    w_flg = r_flags_lat;
    case (r_op)
      OP_ADD16: begin
        w_flg[FLAG_Z] = r_flags_lat[FLAG_Z];
        w_flg[FLAG_N] = 1'b0;
        w_flg[FLAG_H] = w_hc;
        w_flg[FLAG_C] = w_cout;
      end
      OP_ADD_SP_E8: begin
`ifdef ADD16_SP_OFFSET_EN
        w_flg[FLAG_Z] = 1'b0;
        w_flg[FLAG_N] = 1'b0;
        w_flg[FLAG_H] = r_c3;
        w_flg[FLAG_C] = r_c7;
`else
        w_res = r_a;
        w_flg = r_flags_lat;
`endif
      end
      default: w_flg = r_flags_lat;
    endcase
  end

  // Sequencer FSM with registered status and result outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_ADD16;
      r_a         <= 16'h0000;
      r_b         <= 16'h0000;
      r_flags_lat <= 4'b0000;
      r_lo_sum    <= '0;
      r_c7        <= 1'b0;
      r_c3        <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_result    <= 16'h0000;
      o_flags     <= 4'b0000;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_op        <= op_e'(i_op);
            r_a         <= i_op_a;
            r_b         <= w_eff_b;
            r_flags_lat <= i_flags_in;
            r_state     <= ST_LO;
            o_busy      <= 1'b1;
          end
        end
        ST_LO: begin
          r_lo_sum <= w_sum;
          r_c7     <= w_cout;
          r_c3     <= w_hc;
          r_state  <= ST_HI;
        end
        ST_HI: begin
          o_result <= w_res;
          o_flags  <= w_flg;
          o_done   <= 1'b1;
          o_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add16_sequencer.sv
// Self-checking bench for add16_sequencer: directed corner vectors, random ops, timing and reset.
// Drives and samples 1 time unit after each rising edge.
// Expected values come from an arithmetic model of the operation rules.
module tb_add16_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [15:0] i_op_a = 16'h0000;
  logic [15:0] i_op_b = 16'h0000;
  logic [3:0]  i_flags_in = 4'b0000;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_result;
  logic [3:0]  o_flags;

  int checks = 0;
  int failures = 0;

  add16_sequencer #(.WIDTH(8)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_op_a     (i_op_a),
    .i_op_b     (i_op_b),
    .i_flags_in (i_flags_in),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_flags    (o_flags)
  );

  always #5 i_clk = ~i_clk;

  // Reference: 16-bit arithmetic with carries read off integer sums
  function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] f, output logic [15:0] res, output logic [3:0] flg);
    int ai, bi, s, e;
    ai = int'(a);
    bi = int'(b);
    res = a;
    flg = f;
    case (op)
      2'b00: begin
        s = ai + bi;
        res = s[15:0];
        flg = {f[3], 1'b0, (((ai & 'hFFF) + (bi & 'hFFF)) > 'hFFF), (s > 'hFFFF)};
      end
      2'b01: begin
`ifdef ADD16_SP_OFFSET_EN
        e = ((bi & 'hFF) >= 128) ? ((bi & 'hFF) - 256) : (bi & 'hFF);
        s = ai + e;
        res = s[15:0];
        flg = {2'b00, (((ai & 'hF) + (bi & 'hF)) > 'hF), (((ai & 'hFF) + (bi & 'hFF)) > 'hFF)};
`else
        e = 0;
        s = 0;
        res = a;
        flg = f;
`endif
      end
      2'b10: begin s = ai + 1; res = s[15:0]; flg = f; end
      default: begin s = ai - 1; res = s[15:0]; flg = f; end
    endcase
  endfunction

  // Issue one operation and sample done/busy after each of the next three edges
  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] f, output logic [2:0] done_seq, output logic [2:0] busy_seq);
    i_op = op; i_op_a = a; i_op_b = b; i_flags_in = f; i_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      done_seq[k] = o_done;
      busy_seq[k] = o_busy;
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if ({o_busy, o_done, o_result, o_flags} !== 22'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b res=%h flg=%b want all zero", o_busy, o_done, o_result, o_flags);
    end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_directed;
    logic [1:0]  ops [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [15:0] as  [7] = '{16'h0FFF, 16'hFFFF, 16'hFFF8, 16'h0005, 16'h0000, 16'hFFFF, 16'h1234};
    logic [15:0] bs  [7] = '{16'h0001, 16'h0001, 16'h0008, 16'h00FE, 16'h5555, 16'h7777, 16'h0000};
    logic [3:0]  fs  [7] = '{4'b1000, 4'b0000, 4'b1100, 4'b0100, 4'b1010, 4'b0101, 4'b1111};
`ifdef ADD16_SP_OFFSET_EN
    logic [15:0] er  [7] = '{16'h1000, 16'h0000, 16'h0000, 16'h0003, 16'hFFFF, 16'h0000, 16'h1234};
    logic [3:0]  ef  [7] = '{4'b1010, 4'b0011, 4'b0011, 4'b0011, 4'b1010, 4'b0101, 4'b1000};
`else
    logic [15:0] er  [7] = '{16'h1000, 16'h0000, 16'hFFF8, 16'h0005, 16'hFFFF, 16'h0000, 16'h1234};
    logic [3:0]  ef  [7] = '{4'b1010, 4'b0011, 4'b1100, 4'b0100, 4'b1010, 4'b0101, 4'b1000};
`endif
    logic [2:0] d, bz;
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], as[i], bs[i], fs[i], d, bz);
      checks++;
      if (d !== 3'b100 || bz !== 3'b011) begin
        failures++;
        $display("FAIL directed_timing[%0d] got done=%b busy=%b want done=100 busy=011", i, d, bz);
      end
      checks++;
      if (o_result !== er[i] || o_flags !== ef[i]) begin
        failures++;
        $display("FAIL directed_value[%0d] got res=%h flg=%b want res=%h flg=%b", i, o_result, o_flags, er[i], ef[i]);
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_random;
    logic [1:0] op; logic [15:0] a, b, er; logic [3:0] f, ef; logic [2:0] d, bz;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a = 16'($urandom); b = 16'($urandom); f = 4'($urandom);
      if (i < 8) a = (i % 2 == 0) ? 16'hFFFF : 16'h00FF;
      model(op, a, b, f, er, ef);
      do_op(op, a, b, f, d, bz);
      checks++;
      if (d !== 3'b100 || o_result !== er || o_flags !== ef) begin
        failures++;
        $display("FAIL random[%0d] op=%b a=%h b=%h f=%b got done=%b res=%h flg=%b want done=100 res=%h flg=%b",
                 i, op, a, b, f, d, o_result, o_flags, er, ef);
      end
    end
  endtask

  task automatic test_start_ignored;
    logic [15:0] er; logic [3:0] ef; int ndone;
    model(2'b00, 16'h1111, 16'h2222, 4'b0000, er, ef);
    i_op = 2'b00; i_op_a = 16'h1111; i_op_b = 16'h2222; i_flags_in = 4'b0000; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_op_a = 16'hAAAA; i_op_b = 16'hBBBB; i_op = 2'b11;
    ndone = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge i_clk); #1;
      if (k == 1) i_start = 1'b0;
      ndone += int'(o_done);
    end
    checks++;
    if (ndone !== 1 || o_result !== er || o_flags !== ef) begin
      failures++;
      $display("FAIL start_ignored got pulses=%0d res=%h flg=%b want pulses=1 res=%h flg=%b", ndone, o_result, o_flags, er, ef);
    end
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge i_clk); #1;
      ndone += int'(o_done) + int'(o_busy);
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL start_ignored_quiet got busy/done cycles=%0d want 0", ndone);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] er; logic [3:0] ef; logic [2:0] d, bz;
    do_op(2'b10, 16'h00FF, 16'h0000, 4'b0110, d, bz);
    do_op(2'b00, 16'h8000, 16'h8001, 4'b1000, d, bz);
    model(2'b00, 16'h8000, 16'h8001, 4'b1000, er, ef);
    checks++;
    if (d !== 3'b100 || bz !== 3'b011 || o_result !== er || o_flags !== ef) begin
      failures++;
      $display("FAIL back_to_back got done=%b busy=%b res=%h flg=%b want done=100 busy=011 res=%h flg=%b",
               d, bz, o_result, o_flags, er, ef);
    end
  endtask

  task automatic test_reset_in_hi;
    logic [15:0] er; logic [3:0] ef; logic [2:0] d, bz; int ndone;
    i_op = 2'b00; i_op_a = 16'h0F0F; i_op_b = 16'h0101; i_flags_in = 4'b1111; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    checks++;
    if ({o_busy, o_done, o_result, o_flags} !== 22'd0) begin
      failures++;
      $display("FAIL reset_in_hi got busy=%b done=%b res=%h flg=%b want all zero", o_busy, o_done, o_result, o_flags);
    end
    i_rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      ndone += int'(o_done);
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL reset_in_hi_no_done got pulses=%0d want 0", ndone);
    end
    model(2'b11, 16'h1000, 16'h0000, 4'b0001, er, ef);
    do_op(2'b11, 16'h1000, 16'h0000, 4'b0001, d, bz);
    checks++;
    if (d !== 3'b100 || o_result !== er || o_flags !== ef) begin
      failures++;
      $display("FAIL reset_in_hi_recover got done=%b res=%h flg=%b want done=100 res=%h flg=%b", d, o_result, o_flags, er, ef);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_in_hi();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add16_sequencer.md
ADD16_SEQUENCER -- requirements
Module: add16_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning byte width per adder pass; only 8 is supported.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-004 SHALL have port i_start, input, 1, request pulse; accepted only in IDLE.
REQ-005 SHALL have port i_op, input, 2, operation: 00 ADD16, 01 ADD_SP_E8, 10 INC16, 11 DEC16.
REQ-006 SHALL have ports i_op_a and i_op_b, input, 16 each, operands (i_op_b[7:0] only for ADD_SP_E8; ignored for INC16/DEC16).
REQ-007 SHALL have port i_flags_in, input, 4, current flags {Z,N,H,C} at bits 3..0.
REQ-008 SHALL have port o_busy, output, 1, high while a pass is in progress.
REQ-009 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have ports o_result, output, 16, and o_flags, output, 4 ({Z,N,H,C}), both held until next completion.

Function
REQ-011 SHALL implement FSM states IDLE, LO, HI: IDLE->LO on i_start; LO->HI unconditionally; HI->IDLE unconditionally.
REQ-012 SHALL latch i_op, i_op_a, effective B and i_flags_in on the cycle i_start is accepted.
REQ-013 SHALL form effective B: ADD16 i_op_b; ADD_SP_E8 sign-extended i_op_b[7:0]; INC16 0x0001; DEC16 0xFFFF.
REQ-014 SHALL in LO add a[7:0]+B[7:0] with carry-in 0, registering low sum, carry-out of bit 7 and carry-out of bit 3.
REQ-015 SHALL in HI add a[15:8]+B[15:8] with carry-in equal to the registered LO carry, registering carry-out of bit 15 and carry-out of bit 11.
REQ-016 SHALL derive nibble carries as a^b^sum at the next bit (bit 4 of each byte pass).
REQ-017 SHALL produce ADD16 flags: Z = latched Z, N=0, H = bit-11 carry, C = bit-15 carry.
REQ-018 SHALL produce ADD_SP_E8 flags: Z=0, N=0, H = bit-3 carry, C = bit-7 carry of the unsigned low-byte add.
REQ-019 SHALL produce INC16/DEC16 flags equal to latched i_flags_in; results wrap modulo 2^16.
REQ-020 SHALL assert o_done for exactly one cycle, 3 cycles after the accepting i_start edge, updating o_result/o_flags on that same edge.
REQ-021 SHALL drive o_busy high exactly while state is LO or HI.
REQ-022 SHALL ignore i_start while busy; SHALL accept i_start in the cycle o_done is high (back-to-back, one result per 3 cycles).

Reset
REQ-023 SHALL on i_rst_n low at a clock edge force IDLE, o_busy=0, o_done=0, o_result=0x0000, o_flags=4'b0000.
REQ-024 SHALL abandon any in-flight operation on reset with no o_done pulse.

Configuration
REQ-025 SHALL, with macro ADD16_SP_OFFSET_EN defined, implement ADD_SP_E8 per REQ-013/018.
REQ-026 SHALL, without ADD16_SP_OFFSET_EN, treat op 01 as a no-op: same 3-cycle timing, o_result = latched a, o_flags = latched i_flags_in.

Structure
REQ-027 SHALL place op codes, flag bit indices and FSM state encodings in shared package gb80_alu_pkg.
REQ-028 SHALL instantiate exactly one bit_adder (DATA_WIDTH=8), time-shared between LO and HI passes.

Verification
REQ-029 SHALL cover ADD16 a=0x0FFF b=0x0001 flags_in=1000 -> o_result=0x1000, o_flags=1010, o_done 3 cycles after start.
REQ-030 SHALL cover ADD16 a=0xFFFF b=0x0001 flags_in=0000 -> 0x0000, o_flags=0011.
REQ-031 SHALL cover ADD_SP_E8 a=0xFFF8 b=0x0008 -> 0x0000, flags 0011; and a=0x0005 b=0x00FE -> 0x0003, flags 0011; macro off -> result=a, flags=flags_in.
REQ-032 SHALL cover DEC16 a=0x0000 flags_in=1010 -> 0xFFFF, flags 1010; INC16 a=0xFFFF -> 0x0000.
REQ-033 SHALL cover i_start pulsed during LO/HI -> ignored, single o_done; i_start in o_done cycle -> second o_done 3 cycles later.
REQ-034 SHALL cover reset asserted in HI -> no o_done, all outputs zero next cycle, next start completes normally.
